// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder family.
package adder_pkg;

  // Per-stage control bits. The data fields (sum_lo/a_hi via the shifting lane,
  // b_hi via the skew register) change width from stage to stage, so they are
  // declared inside each stage's generate block instead of in this struct.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;   // only meaningful in the stage that adds the MSB segment
  } stage_ctrl_t;

  // Pipeline depth: one stage per SEG-bit segment. Guarded against SEG == 0 so
  // the legality check below can report the problem instead of a divide error.
  function automatic int unsigned calc_nstage(input int unsigned width,
                                              input int unsigned seg);
    return (seg == 0) ? 1 : width / seg;
  endfunction

  // Segment size must be non-zero and divide the word evenly.
  function automatic bit seg_legal(input int unsigned width, input int unsigned seg);
    return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry adder slice; one instance per pipeline stage.
module rca_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           carry_msb_in
);

  logic [SEG:0] c;

  // Bit-serial ripple: c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(SEG); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout         = c[SEG];
  // Carry into the top bit of the slice; used for signed overflow in the last stage.
  assign carry_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Each stage adds one SEG-bit segment; the carry is registered between stages.
module pipelined_rca
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSTAGE = calc_nstage(WIDTH, SEG);

  if (!seg_legal(WIDTH, SEG)) begin : g_param_check
    $error("pipelined_rca: SEG must be >= 1 and divide WIDTH");
  end

  // Whole pipe moves together; a full pipe with a blocked output freezes,
  // bubbles included.
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  // Subtract as A + ~B + 1; cin is ignored in subtract mode.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned InW = WIDTH - k * SEG;  // b bits not yet consumed

    logic [InW-1:0]   b_in;
    // Lane: unconsumed a bits in the low part, finished sum segments shifted in
    // from the top. After the last stage it holds exactly the sum.
    logic [WIDTH-1:0] lane_in;
    logic [WIDTH-1:0] lane_d;
    logic [WIDTH-1:0] lane_q;
    logic             c_in;
    logic             v_in;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_msb;
    stage_ctrl_t      ctrl_d;
    stage_ctrl_t      ctrl_q;

    if (k == 0) begin : g_head
      assign b_in    = b_eff;
      assign lane_in = a;
      assign c_in    = c0;
      assign v_in    = in_valid;
    end else begin : g_body
      assign b_in    = g_stage[k-1].g_skew.b_rem_q;
      assign lane_in = g_stage[k-1].lane_q;
      assign c_in    = g_stage[k-1].ctrl_q.carry;
      assign v_in    = g_stage[k-1].ctrl_q.valid;
    end

    rca_segment #(
      .SEG(SEG)
    ) u_seg (
      .a           (lane_in[SEG-1:0]),
      .b           (b_in[SEG-1:0]),
      .cin         (c_in),
      .sum         (seg_sum),
      .cout        (seg_cout),
      .carry_msb_in(seg_msb)
    );

    if (WIDTH == SEG) begin : g_lane_single
      assign lane_d = seg_sum;
    end else begin : g_lane_shift
      assign lane_d = {seg_sum, lane_in[WIDTH-1:SEG]};
    end

    assign ctrl_d = '{valid: v_in, carry: seg_cout, ovf: seg_msb ^ seg_cout};

    // Stage register: valid, carry, overflow and the sum/a lane.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_q <= '0;
        lane_q <= '0;
      end else if (advance) begin
        ctrl_q <= ctrl_d;
        lane_q <= lane_d;
      end
    end

    if (k < NSTAGE - 1) begin : g_skew
      logic [InW-SEG-1:0] b_rem_q;

      // Skew register: the b bits later stages still have to add.
      always_ff @(posedge clk) begin
        if (rst) begin
          b_rem_q <= '0;
        end else if (advance) begin
          b_rem_q <= b_in[InW-1:SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].ctrl_q.valid;
  assign sum       = g_stage[NSTAGE-1].lane_q;
  assign cout      = g_stage[NSTAGE-1].ctrl_q.carry;
  assign ovf       = g_stage[NSTAGE-1].ctrl_q.ovf;

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca: 16/4 (main), 32/8 and 8/8 instances.
module tb_pipelined_rca;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec16_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec32_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec8_t;

  logic clk;
  logic rst;
  logic out_ready;

  logic        in_valid, in_ready, cin, sub, out_valid, cout, ovf;
  logic [15:0] a, b, sum;

  logic        iv32, ir32, cin32, sub32, ov32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  logic        iv8, ir8, cin8, sub8, ov8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int n_cmp = 0;
  int n_bad = 0;

  vec16_t tbl[8];
  vec16_t sng[6];
  vec32_t t32[4];
  vec8_t  t8[3];

  pipelined_rca #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  pipelined_rca #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(out_ready), .sum(sum32),
    .cout(cout32), .ovf(ovf32)
  );

  pipelined_rca #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(out_ready), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive16(input vec16_t v);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
  endtask

  task automatic chk16(input string tag, input vec16_t v);
    chk({tag, "_sum"}, 64'(sum), 64'(v.s));
    chk({tag, "_cout"}, 64'(cout), 64'(v.c));
    chk({tag, "_ovf"}, 64'(ovf), 64'(v.o));
  endtask

  // One isolated beat: checks the 4-cycle latency and the result.
  task automatic single16(input string tag, input vec16_t v);
    drive16(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk16(tag, v);
    step();
  endtask

  initial begin
    // Hand-computed vectors.
    sng[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    sng[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    sng[2] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    sng[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    sng[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    sng[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};  // cin ignored

    tbl[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[7] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    t32[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    t32[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    t32[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    t32[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};

    t8[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    t8[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    t8[2] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

    // Reset state.
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Isolated beats with latency check.
    single16("carry_wrap", sng[0]);
    single16("ovf_add", sng[1]);
    single16("add_cin", sng[2]);
    single16("sub_borrow", sng[3]);
    single16("sub_ovf", sng[4]);
    single16("sub_cin_ign", sng[5]);

    // Eight back-to-back beats, alternating mode; results on consecutive cycles.
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        drive16(tbl[i]);
        in_valid = 1'b1;
        chk($sformatf("b2b%0d_in_ready", i), 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 3) begin
        chk($sformatf("b2b%0d_valid", i - 3), 64'(out_valid), 64'd1);
        chk16($sformatf("b2b%0d", i - 3), tbl[i - 3]);
      end
    end
    step();
    chk("b2b_empty", 64'(out_valid), 64'd0);

    // Fill the pipe, then block the output for 3 cycles with a beat waiting.
    for (int i = 0; i < 4; i++) begin
      drive16(tbl[i]);
      in_valid = 1'b1;
      step();
    end
    drive16(tbl[4]);
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("stall%0d_in_ready", s), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_valid", s), 64'(out_valid), 64'd1);
      chk16($sformatf("stall%0d", s), tbl[0]);
      step();
    end
    chk("stall_end_valid", 64'(out_valid), 64'd1);
    chk16("stall_end", tbl[0]);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("drain%0d_valid", j), 64'(out_valid), 64'd1);
      chk16($sformatf("drain%0d", j), tbl[j]);
      step();
      in_valid = 1'b0;
    end
    chk("drain_no_dup", 64'(out_valid), 64'd0);

    // Reset with 3 beats in flight and a beat offered during reset.
    for (int i = 5; i < 8; i++) begin
      drive16(tbl[i]);
      in_valid = 1'b1;
      step();
    end
    rst = 1'b1;
    drive16(tbl[0]);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    chk("mid_rst_cout", 64'(cout), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("no_stale%0d", i), 64'(out_valid), 64'd0);
    end

    // WIDTH=32, SEG=8: four back-to-back beats, latency 4.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        a32 = t32[i].a; b32 = t32[i].b; cin32 = t32[i].cin; sub32 = t32[i].sub;
        iv32 = 1'b1;
      end else begin
        iv32 = 1'b0;
      end
      step();
      if (i >= 3) begin
        chk($sformatf("w32_%0d_valid", i - 3), 64'(ov32), 64'd1);
        chk($sformatf("w32_%0d_sum", i - 3), 64'(sum32), 64'(t32[i - 3].s));
        chk($sformatf("w32_%0d_cout", i - 3), 64'(cout32), 64'(t32[i - 3].c));
        chk($sformatf("w32_%0d_ovf", i - 3), 64'(ovf32), 64'(t32[i - 3].o));
      end
    end

    // WIDTH=8, SEG=8: single stage, result valid the cycle after acceptance.
    for (int i = 0; i < 3; i++) begin
      a8 = t8[i].a; b8 = t8[i].b; cin8 = t8[i].cin; sub8 = t8[i].sub;
      iv8 = 1'b1;
      step();
      chk($sformatf("w8_%0d_valid", i), 64'(ov8), 64'd1);
      chk($sformatf("w8_%0d_sum", i), 64'(sum8), 64'(t8[i].s));
      chk($sformatf("w8_%0d_cout", i), 64'(cout8), 64'(t8[i].c));
      chk($sformatf("w8_%0d_ovf", i), 64'(ovf8), 64'(t8[i].o));
    end
    iv8 = 1'b0;
    step();
    chk("w8_empty", 64'(ov8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
